// File: rtl/song_session_ctrl_if.sv
// Session bus between board controls / music player (master) and song_session_ctrl (slave).
// The signal names keep the controller's _i/_o port direction suffixes.
interface song_session_if;
  logic        start_i;
  logic        stop_i;
  logic        pause_i;
  logic [1:0]  song_sel_i;
  logic [1:0]  difficulty_i;
  logic [15:0] bpm_i;
  logic        player_done_i;
  logic        play_o;
  logic [1:0]  song_sel_o;
  logic [1:0]  difficulty_o;
  logic [15:0] bpm_o;
  logic        beat_tick_o;
  logic [11:0] beat_num_o;
  logic [2:0]  countin_o;
  logic [2:0]  state_o;
  logic        busy_o;
  logic        session_done_o;

  modport master (
    output start_i, stop_i, pause_i, song_sel_i, difficulty_i, bpm_i, player_done_i,
    input  play_o, song_sel_o, difficulty_o, bpm_o, beat_tick_o, beat_num_o,
           countin_o, state_o, busy_o, session_done_o
  );

  modport slave (
    input  start_i, stop_i, pause_i, song_sel_i, difficulty_i, bpm_i, player_done_i,
    output play_o, song_sel_o, difficulty_o, bpm_o, beat_tick_o, beat_num_o,
           countin_o, state_o, busy_o, session_done_o
  );
endinterface

// File: rtl/song_session_ctrl.sv
// Play-session sequencer: latch config, BPM phase-accumulator beat, count-in, play/pause/finish.
// All outputs registered (1 cycle after the deciding edge); no backpressure. SESSION_LOOP_EN loops sessions.
module song_session_ctrl #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned COUNTIN_BEATS = 4,
  parameter int unsigned DEFAULT_BPM   = 120,
  parameter int unsigned MAX_BPM       = 300
) (
  input  logic         clk,
  input  logic         resetn,
  song_session_if.slave bus
);
  localparam logic [2:0]  S_IDLE    = 3'd0;
  localparam logic [2:0]  S_LOAD    = 3'd1;
  localparam logic [2:0]  S_COUNTIN = 3'd2;
  localparam logic [2:0]  S_PLAY    = 3'd3;
  localparam logic [2:0]  S_PAUSE   = 3'd4;
  localparam logic [2:0]  S_FINISH  = 3'd5;
  localparam logic [32:0] PER       = 33'(CLK_HZ) * 33'd60;
  localparam logic [15:0] MAX_B     = 16'(MAX_BPM);
  localparam logic [15:0] DEF_B     = 16'(DEFAULT_BPM);
  localparam logic [2:0]  CNT_INIT  = 3'(COUNTIN_BEATS);

  logic [2:0]  state_q, state_d;
  logic        start_q, armed_q, start_edge;
  logic [31:0] acc_q, acc_d;
  logic [32:0] acc_sum, acc_wrap;
  logic        adv, tick_c;
  logic        play_q, play_d, tick_q, tick_d, done_q, done_d;
  logic [1:0]  song_q, song_d, diff_q, diff_d;
  logic [15:0] bpm_q, bpm_d, bpm_san;
  logic [11:0] beat_q, beat_d;
  logic [2:0]  cnt_q, cnt_d;

  // armed_q blocks a start level held high across reset release from looking like an edge
  assign start_edge = bus.start_i & ~start_q & armed_q & (state_q == S_IDLE);
  assign bpm_san    = (bus.bpm_i == 16'd0 || bus.bpm_i > MAX_B) ? DEF_B : bus.bpm_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_edge) state_d = S_LOAD;
      S_LOAD:    state_d = bus.stop_i ? S_IDLE : S_COUNTIN;
      S_COUNTIN: begin
        if (bus.stop_i)                       state_d = S_IDLE;
        else if (tick_q && cnt_q == 3'd1)     state_d = S_PLAY;
      end
      S_PLAY: begin
        if (bus.stop_i)                       state_d = S_IDLE;
        else if (bus.player_done_i)           state_d = S_FINISH;
        else if (bus.pause_i)                 state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (bus.stop_i)                       state_d = S_IDLE;
        else if (bus.player_done_i)           state_d = S_FINISH;
        else if (!bus.pause_i)                state_d = S_PLAY;
      end
`ifdef SESSION_LOOP_EN
      S_FINISH:  state_d = bus.stop_i ? S_IDLE : S_COUNTIN;
`else
      S_FINISH:  state_d = S_IDLE;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // The pause-exit cycle already advances, so a pause of N cycles delays the beat by exactly N.
  always_comb begin
    acc_sum  = {1'b0, acc_q} + {17'd0, bpm_q};
    acc_wrap = acc_sum - PER;
    adv      = !bus.stop_i && ((state_q == S_COUNTIN) ||
               ((state_q == S_PLAY || state_q == S_PAUSE) && !bus.player_done_i && !bus.pause_i));
    tick_c   = adv && (acc_sum >= PER);
    acc_d    = acc_q;
    song_d   = song_q;
    diff_d   = diff_q;
    bpm_d    = bpm_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    tick_d   = tick_c;
    play_d   = (state_d == S_PLAY);
    done_d   = (state_d == S_FINISH);
    if (adv) acc_d = tick_c ? acc_wrap[31:0] : acc_sum[31:0];
    if (state_q == S_COUNTIN && tick_q && !bus.stop_i) cnt_d = cnt_q - 3'd1;
    if (state_q == S_PLAY && tick_q && !bus.stop_i && beat_q != 12'hFFF) beat_d = beat_q + 12'd1;
    if (state_q == S_LOAD && !bus.stop_i) begin
      song_d = bus.song_sel_i;
      diff_d = bus.difficulty_i;
      bpm_d  = bpm_san;
      acc_d  = 32'd0;
      beat_d = 12'd0;
      cnt_d  = CNT_INIT;
    end
`ifdef SESSION_LOOP_EN
    if (state_q == S_FINISH && !bus.stop_i) begin
      acc_d  = 32'd0;
      beat_d = 12'd0;
      cnt_d  = CNT_INIT;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q <= 1'b0;
      armed_q <= 1'b0;
      acc_q   <= 32'd0;
      tick_q  <= 1'b0;
      play_q  <= 1'b0;
      done_q  <= 1'b0;
      song_q  <= 2'd0;
      diff_q  <= 2'd0;
      bpm_q   <= 16'd0;
      beat_q  <= 12'd0;
      cnt_q   <= 3'd0;
    end else begin
      start_q <= bus.start_i;
      armed_q <= 1'b1;
      acc_q   <= acc_d;
      tick_q  <= tick_d;
      play_q  <= play_d;
      done_q  <= done_d;
      song_q  <= song_d;
      diff_q  <= diff_d;
      bpm_q   <= bpm_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.play_o         = play_q;
  assign bus.song_sel_o     = song_q;
  assign bus.difficulty_o   = diff_q;
  assign bus.bpm_o          = bpm_q;
  assign bus.beat_tick_o    = tick_q;
  assign bus.beat_num_o     = beat_q;
  assign bus.countin_o      = cnt_q;
  assign bus.state_o        = state_q;
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.session_done_o = done_q;
endmodule

// File: tb/tb_song_session_ctrl.sv
// Bench for song_session_ctrl: vector table, hand-written corner sequences, random lockstep model.
module tb_song_session_ctrl;
  localparam int     CB  = 4;
  localparam longint PER = 6000;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  song_session_if bus();
  song_session_ctrl #(.CLK_HZ(100), .COUNTIN_BEATS(CB), .DEFAULT_BPM(120), .MAX_BPM(300))
    dut (.clk(clk), .resetn(resetn), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference: beats come from floor(k*bpm/PER) stepping, k = cycles the beat clock has run.
  logic [2:0]  m_state, m_cnt;
  logic        m_startq, m_armed, m_tick, m_play, m_done;
  logic [1:0]  m_song, m_diff;
  logic [15:0] m_bpm;
  logic [11:0] m_beat;
  longint      m_k;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_startq = 0; m_armed = 0; m_tick = 0; m_play = 0;
    m_done = 0; m_song = 0; m_diff = 0; m_bpm = 0; m_beat = 0; m_k = 0;
  endtask

  task automatic model_step();
    logic [2:0] ns;
    logic run, tk, stop, done, pause;
    stop = bus.stop_i; done = bus.player_done_i; pause = bus.pause_i;
    ns = m_state;
    run = 1'b0;
    case (m_state)
      3'd0: if (bus.start_i && !m_startq && m_armed) ns = 3'd1;
      3'd1: ns = stop ? 3'd0 : 3'd2;
      3'd2: if (stop) ns = 3'd0; else begin run = 1'b1; if (m_tick && m_cnt == 3'd1) ns = 3'd3; end
      3'd3: if (stop) ns = 3'd0; else if (done) ns = 3'd5; else if (pause) ns = 3'd4; else run = 1'b1;
      3'd4: if (stop) ns = 3'd0; else if (done) ns = 3'd5; else if (!pause) begin ns = 3'd3; run = 1'b1; end
      default: ns = 3'd0;
    endcase
    tk = run && (((m_k + 1) * longint'(m_bpm)) / PER != (m_k * longint'(m_bpm)) / PER);
    if (m_state == 3'd2 && m_tick && !stop) m_cnt = m_cnt - 3'd1;
    if (m_state == 3'd3 && m_tick && !stop && m_beat < 12'd4095) m_beat = m_beat + 12'd1;
    if (m_state == 3'd1 && !stop) begin
      m_song = bus.song_sel_i;
      m_diff = bus.difficulty_i;
      m_bpm  = (bus.bpm_i == 0 || bus.bpm_i > 300) ? 16'd120 : bus.bpm_i;
      m_k = 0; m_beat = 0; m_cnt = 3'(CB);
    end
    if (run) m_k++;
    m_tick = tk; m_play = (ns == 3'd3); m_done = (ns == 3'd5);
    m_state = ns; m_startq = bus.start_i; m_armed = 1'b1;
  endtask

  function automatic longint dut_vec();
    return {bus.play_o, bus.song_sel_o, bus.difficulty_o, bus.bpm_o, bus.beat_tick_o,
            bus.beat_num_o, bus.countin_o, bus.state_o, bus.busy_o, bus.session_done_o};
  endfunction

  function automatic longint model_vec();
    return {m_play, m_song, m_diff, m_bpm, m_tick, m_beat, m_cnt, m_state,
            (m_state != 3'd0), m_done};
  endfunction

  task automatic tick_cyc();
    @(posedge clk);
    if (!resetn) model_reset(); else model_step();
    @(negedge clk);
    check("lockstep", dut_vec(), model_vec());
  endtask

  task automatic start_session();
    bus.start_i = 1'b0; tick_cyc();
    bus.start_i = 1'b1; tick_cyc();
    check("enter_load", bus.state_o, 1);
    tick_cyc();
    check("enter_countin", bus.state_o, 2);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin tick_cyc(); n++; end while (!bus.beat_tick_o && n < limit);
    check("tick_seen", bus.beat_tick_o, 1);
  endtask

  task automatic wait_state(input int s, input int limit);
    int n = 0;
    while (bus.state_o != 3'(s) && n < limit) begin tick_cyc(); n++; end
    check("wait_state", bus.state_o, s);
  endtask

  typedef struct {
    logic [15:0] bpm;
    logic [1:0]  song;
    logic [1:0]  diff;
    logic [15:0] exp_bpm;
    int          exp_gap;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n, m, ticks, last, bad_sp;
    vecs[0] = '{16'd120, 2'd1, 2'd2, 16'd120, 50};
    vecs[1] = '{16'd0,   2'd3, 2'd0, 16'd120, 50};
    vecs[2] = '{16'd400, 2'd2, 2'd1, 16'd120, 50};
    vecs[3] = '{16'd7,   2'd0, 2'd3, 16'd7,   858};
    vecs[4] = '{16'd300, 2'd1, 2'd1, 16'd300, 20};
    vecs[5] = '{16'd301, 2'd2, 2'd2, 16'd120, 50};
    vecs[6] = '{16'd1,   2'd3, 2'd3, 16'd1,   6000};

    bus.start_i = 1'b1; bus.stop_i = 1'b0; bus.pause_i = 1'b0; bus.player_done_i = 1'b0;
    bus.song_sel_i = 2'd0; bus.difficulty_i = 2'd0; bus.bpm_i = 16'd120;
    model_reset();
    #1 resetn = 1'b0;
    repeat (3) tick_cyc();
    check("reset_outputs", dut_vec(), 0);
    resetn = 1'b1;
    repeat (5) tick_cyc();
    check("held_start_no_edge", bus.state_o, 0);
    start_session();
    bus.stop_i = 1'b1; tick_cyc(); bus.stop_i = 1'b0;
    check("stop_from_countin", bus.state_o, 0);

    for (int i = 0; i < 7; i++) begin
      bus.bpm_i = vecs[i].bpm; bus.song_sel_i = vecs[i].song; bus.difficulty_i = vecs[i].diff;
      start_session();
      bus.bpm_i = 16'd250; bus.song_sel_i = ~vecs[i].song; bus.difficulty_i = ~vecs[i].diff;
      wait_tick(10000, n);
      check("vec_gap", n, vecs[i].exp_gap);
      check("vec_bpm", bus.bpm_o, vecs[i].exp_bpm);
      check("vec_song", bus.song_sel_o, vecs[i].song);
      check("vec_diff", bus.difficulty_o, vecs[i].diff);
      bus.stop_i = 1'b1; tick_cyc(); bus.stop_i = 1'b0;
      check("vec_stop_idle", bus.state_o, 0);
      check("vec_bpm_held", bus.bpm_o, vecs[i].exp_bpm);
    end

    // count-in, play start, beat counting, pause
    bus.bpm_i = 16'd120;
    start_session();
    for (int t = 1; t <= 4; t++) begin
      wait_tick(100, n);
      check("countin_gap", n, 50);
      check("countin_val", bus.countin_o, 5 - t);
    end
    check("play_not_yet", bus.play_o, 0);
    tick_cyc();
    check("play_after_4th", bus.play_o, 1);
    check("state_play", bus.state_o, 3);
    check("countin_zero", bus.countin_o, 0);
    wait_tick(100, n); check("play_gap1", n, 49);
    wait_tick(100, n); check("play_gap2", n, 50);
    wait_tick(100, n); check("play_gap3", n, 50);
    tick_cyc();
    check("beat_num_3", bus.beat_num_o, 3);
    repeat (19) tick_cyc();
    bus.pause_i = 1'b1;
    repeat (30) tick_cyc();
    check("paused_state", bus.state_o, 4);
    check("paused_play_o", bus.play_o, 0);
    bus.pause_i = 1'b0;
    wait_tick(200, m);
    check("pause_delay", 20 + 30 + m, 80);
    bus.player_done_i = 1'b1; bus.stop_i = 1'b1; tick_cyc();
    bus.player_done_i = 1'b0; bus.stop_i = 1'b0;
    check("stop_beats_done_state", bus.state_o, 0);
    check("stop_no_session_done", bus.session_done_o, 0);
    check("beat_num_held", bus.beat_num_o, 3);

    // natural completion
    start_session();
    wait_state(3, 500);
    repeat (5) tick_cyc();
    bus.player_done_i = 1'b1; tick_cyc(); bus.player_done_i = 1'b0;
    check("done_pulse", bus.session_done_o, 1);
    check("done_finish", bus.state_o, 5);
    check("done_play_off", bus.play_o, 0);
    tick_cyc();
    check("done_pulse_end", bus.session_done_o, 0);
    check("done_to_idle", bus.state_o, 0);

    // done in COUNTIN ignored, then async reset during PLAY
    start_session();
    bus.player_done_i = 1'b1; tick_cyc(); bus.player_done_i = 1'b0;
    check("done_ignored_countin", bus.state_o, 2);
    wait_state(3, 500);
    wait_tick(100, n); wait_tick(100, n); tick_cyc();
    check("pre_reset_beats", bus.beat_num_o, 2);
    #2 resetn = 1'b0;
    #1;
    check("areset_play", bus.play_o, 0);
    check("areset_beat", bus.beat_num_o, 0);
    check("areset_state", bus.state_o, 0);
    model_reset();
    tick_cyc();
    resetn = 1'b1;
    tick_cyc();

    // bpm 7: seven beats in 6000 cycles, spacing 857/858
    bus.bpm_i = 16'd7;
    start_session();
    ticks = 0; last = 0; bad_sp = 0;
    for (int c = 1; c <= 6000; c++) begin
      tick_cyc();
      if (bus.beat_tick_o) begin
        if (ticks > 0 && (c - last) != 857 && (c - last) != 858) bad_sp++;
        ticks++; last = c;
      end
    end
    check("bpm7_ticks", ticks, 7);
    check("bpm7_spacing", bad_sp, 0);
    bus.stop_i = 1'b1; tick_cyc(); bus.stop_i = 1'b0;

    // random stimulus against the model
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 7) == 0)  bus.start_i = ~bus.start_i;
      if ($urandom_range(0, 59) == 0) bus.pause_i = ~bus.pause_i;
      bus.stop_i        = ($urandom_range(0, 249) == 0);
      bus.player_done_i = ($urandom_range(0, 299) == 0);
      bus.song_sel_i    = 2'($urandom);
      bus.difficulty_i  = 2'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0:       bus.bpm_i = 16'd0;
          1:       bus.bpm_i = 16'd400;
          2:       bus.bpm_i = 16'd300;
          default: bus.bpm_i = 16'($urandom_range(150, 300));
        endcase
      end
      tick_cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
